// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register plus IF/ID pipeline register, with redirect/stall handling.
// Optional macro FETCH_MISALIGN_CHECK_EN aligns redirect targets to a word and flags misaligned ones.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic [31:0] endereco,
   input  logic [31:0] instrucao,
   output logic [31:0] pc,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
   output logic [31:0] fetch_count,
   output logic        fetch_misaligned
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] ipc_q, ipc_d;
   logic [31:0] ipc4_q, ipc4_d;
   logic        valid_q, valid_d;
   logic [31:0] count_q, count_d;
   logic        misal_q, misal_d;
   logic [31:0] pc_plus4;
   logic [31:0] target_pc;
   logic        target_misal;

   assign pc_plus4 = pc_q + 32'd4;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign target_pc    = {redirect_target[31:2], 2'b00};
   assign target_misal = (redirect_target[1:0] != 2'b00);
`else
   assign target_pc    = redirect_target;
   assign target_misal = 1'b0;
`endif

   // Redirect beats stall; the wrong-path instruction on instrucao is dropped.
   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      ipc4_d  = ipc4_q;
      valid_d = valid_q;
      count_d = count_q;
      misal_d = 1'b0;
      if (redirect) begin
         pc_d    = target_pc;
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
         misal_d = target_misal;
      end else if (!stall) begin
         pc_d    = pc_plus4;
         instr_d = instrucao;
         ipc_d   = pc_q;
         ipc4_d  = pc_plus4;
         valid_d = 1'b1;
         count_d = count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         ipc_q   <= 32'd0;
         ipc4_q  <= 32'd0;
         valid_q <= 1'b0;
         count_q <= 32'd0;
         misal_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         ipc4_q  <= ipc4_d;
         valid_q <= valid_d;
         count_q <= count_d;
         misal_q <= misal_d;
      end
   end

   assign endereco         = pc_q;
   assign pc               = pc_q;
   assign if_id_instr      = instr_q;
   assign if_id_pc         = ipc_q;
   assign if_id_pc4        = ipc4_q;
   assign if_id_valid      = valid_q;
   assign fetch_count      = count_q;
   assign fetch_misaligned = misal_q;

endmodule
